small_calculator_arbiter: RTL and testbench
===========================================

# small_calculator_arbiter

Round-robin arbiter and sequencer that shares one `small_calculator` between four requesters. It accepts one request at a time, loads that requester's opcode and operands onto the calculator, and pulses `go`. It then waits for `done`, captures the result and returns it to the winning requester with a one-cycle acknowledge. It sits between the requester logic and the calculator top, and is the only driver of the calculator's `go`, `op` and operand inputs.

## Interface
Parameters:
- `W`, 4: operand and result width.
- `TIMEOUT`, 15: WAIT-state cycle limit. Used only with `SCA_TIMEOUT_EN`; legal range 5..255.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req`  in  4  per-requester request, level.
- `req_op`  in  8  packed 2-bit opcodes; requester i uses bits [2i+1:2i].
- `req_in1`  in  4*W  packed operand A; requester i uses [W*i+W-1:W*i].
- `req_in2`  in  4*W  packed operand B, same packing as `req_in1`.
- `ack`  out  4  one-hot, one-cycle completion pulse.
- `result`  out  W  result; valid in the `ack` cycle, held until the next `ack`.
- `err`  out  1  timeout flag; valid with `ack`.
- `busy`  out  1  high in every state except IDLE.
- `calc_go`  out  1  calculator start.
- `calc_op`  out  2  calculator opcode.
- `calc_in1`, `calc_in2`  out  W  calculator operands.
- `calc_done`  in  1  calculator done.
- `calc_out`  in  W  calculator result.

## Operation
- States: DRAIN, IDLE, ISSUE, WAIT, RESP. The reset state is DRAIN.
- **DRAIN**
  - A 3-bit counter counts 4 cycles with `calc_go` held at 0. The calculator has no reset, and 4 cycles guarantees it has returned to its idle state.
  - After 4 cycles the state goes to IDLE.
- **IDLE**
  - If any `req` bit is set, grant the first set bit at or after pointer `ptr`, searching in increasing index order mod 4.
  - On a grant: latch the grant index, that requester's op and operands into `calc_op`/`calc_in1`/`calc_in2`, and go to ISSUE.
- **ISSUE**
  - `calc_go`=1 for exactly this cycle; next state is WAIT.
  - `ptr` becomes grant+1 mod 4.
- **WAIT**
  - `calc_go`=0.
  - When `calc_done`=1: register `calc_out` into `result`, set `err`=0, go to RESP.
- **RESP**
  - `ack[grant]`=1 for this cycle only; next state is IDLE.
- `calc_op`, `calc_in1` and `calc_in2` are registers. They change only on a grant and stay stable through the whole calculator sequence.
- Requests are sampled only in IDLE. `req` bits that change while busy are ignored.
- A requester that keeps `req` high in the cycle after its `ack` is treated as a new request.
- Arithmetic and width: `result` is `calc_out` passed through unchanged (W bits). The arbiter does no computation.

## Timing
- Reset values:
  - state DRAIN, `ptr`=0, drain counter 0.
  - `ack`=0, `result`=0, `err`=0, `busy`=1.
  - `calc_go`=0, `calc_op`=0, `calc_in1`=0, `calc_in2`=0.
- Latency, with the calculator responding nominally (`done` 4 cycles after `go`):
  - `req` seen in IDLE at cycle t.
  - `calc_go` at t+1.
  - `calc_done` at t+5.
  - `ack` at t+6.
- Next grant is possible at t+7, so the minimum request-to-request period is 7 cycles.
- Simultaneous requests: one grant per IDLE cycle, order by `ptr`. With all four requesting continuously, grants go 0,1,2,3,0...
- `calc_done` arriving in ISSUE is ignored. Only WAIT samples `calc_done`.
- Reset asserted mid-operation: the next edge forces DRAIN.
  - `ack` and `calc_go` drop immediately.
  - Any in-flight request is discarded and gets no `ack`.
  - After the 4 drain cycles the arbiter returns to IDLE.

## Configuration
- `SCA_TIMEOUT_EN` defined:
  - An 8-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches `TIMEOUT` with no `calc_done`, go to DRAIN via RESP: `ack[grant]`=1, `result`=0, `err`=1.
  - After such a RESP the next state is DRAIN, not IDLE.
- `SCA_TIMEOUT_EN` undefined: WAIT waits indefinitely, `err` is tied to 0, and the counter is not built.

## Test plan
- Reset, then `req`=0001, op=00, in1=3, in2=5 held → `busy` stays 1 for 4 cycles. Then `calc_go` pulses once, `ack`=0001 six cycles after the IDLE sample, `result`=8, `err`=0.
- `req`=1111 held with per-requester ops ADD/SUB/AND/XOR on 4'hA/4'h6 → `ack` order 0,1,2,3,0; results 0, 4, 2, C; 7-cycle spacing.
- `ptr`=2 after a grant to 1, then `req`=0011 → grant 0 (wrap-around), next `ptr`=1.
- `rst_n` low for 1 cycle while in WAIT → no `ack` for the discarded request. DRAIN takes 4 cycles, then a still-held `req` is granted normally with the correct result.
- `SCA_TIMEOUT_EN`, `TIMEOUT`=6, calculator model never asserts `calc_done` → `ack` with `result`=0 and `err`=1. The arbiter then goes to DRAIN and a later good request completes with `err`=0.

Source files
------------

// File: rtl/small_calculator_arbiter.sv
// Round-robin arbiter/sequencer that shares one small_calculator between four requesters.
// Optional WAIT-state timeout is built only when SCA_TIMEOUT_EN is defined.
module small_calculator_arbiter #(
  parameter int W       = 4,
  parameter int TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [3:0]     req,
  input  logic [7:0]     req_op,
  input  logic [4*W-1:0] req_in1,
  input  logic [4*W-1:0] req_in2,
  output logic [3:0]     ack,
  output logic [W-1:0]   result,
  output logic           err,
  output logic           busy,
  output logic           calc_go,
  output logic [1:0]     calc_op,
  output logic [W-1:0]   calc_in1,
  output logic [W-1:0]   calc_in2,
  input  logic           calc_done,
  input  logic [W-1:0]   calc_out
);

  typedef enum logic [2:0] {DRAIN, IDLE, ISSUE, WAIT, RESP} state_t;

  state_t     state_q, state_d;
  logic [2:0] drain_cnt_q, drain_cnt_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] grant_q, grant_d;
  logic [1:0] op_q, op_d;
  logic [W-1:0] in1_q, in1_d;
  logic [W-1:0] in2_q, in2_d;
  logic [W-1:0] result_q, result_d;
  logic [1:0] pick;
  logic [1:0] idx;
  logic       timeout_hit;

  // First set request at or after ptr; scanning downward leaves the nearest one.
  always_comb begin
    pick = ptr_q;
    idx  = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr_q + 2'(k);
      if (req[idx]) pick = idx;
    end
  end

`ifdef SCA_TIMEOUT_EN
  logic [7:0] tcnt_q, tcnt_d;
  logic       err_q, err_d;

  always_comb begin
    tcnt_d = tcnt_q;
    err_d  = err_q;
    if (state_q == ISSUE) tcnt_d = '0;
    else if (state_q == WAIT) tcnt_d = tcnt_q + 8'd1;
    if (state_q == WAIT && calc_done) err_d = 1'b0;
    else if (timeout_hit) err_d = 1'b1;
  end

  assign timeout_hit = (state_q == WAIT) && !calc_done && (tcnt_q + 8'd1 == 8'(TIMEOUT));
  assign err = err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      err_q  <= err_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= DRAIN;
      drain_cnt_q <= '0;
      ptr_q       <= '0;
      grant_q     <= '0;
      op_q        <= '0;
      in1_q       <= '0;
      in2_q       <= '0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      op_q        <= op_d;
      in1_q       <= in1_d;
      in2_q       <= in2_d;
      result_q    <= result_d;
    end
  end

  // The drain counter rests at zero outside DRAIN, so every entry starts a fresh 4-cycle drain.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = '0;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    op_d        = op_q;
    in1_d       = in1_q;
    in2_d       = in2_q;
    result_d    = result_q;
    case (state_q)
      DRAIN: begin
        drain_cnt_d = drain_cnt_q + 3'd1;
        if (drain_cnt_q == 3'd3) state_d = IDLE;
      end
      IDLE: begin
        if (|req) begin
          grant_d = pick;
          op_d    = req_op[{pick, 1'b0} +: 2];
          in1_d   = req_in1[W*int'(pick) +: W];
          in2_d   = req_in2[W*int'(pick) +: W];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        ptr_d   = grant_q + 2'd1;
        state_d = WAIT;
      end
      WAIT: begin
        if (calc_done) begin
          result_d = calc_out;
          state_d  = RESP;
        end else if (timeout_hit) begin
          result_d = '0;
          state_d  = RESP;
        end
      end
      RESP: state_d = err ? DRAIN : IDLE;
      default: state_d = DRAIN;
    endcase
  end

  always_comb begin
    ack      = (state_q == RESP) ? (4'b0001 << grant_q) : 4'b0000;
    calc_go  = (state_q == ISSUE);
    busy     = (state_q != IDLE);
    result   = result_q;
    calc_op  = op_q;
    calc_in1 = in1_q;
    calc_in2 = in2_q;
  end

endmodule

// File: tb/tb_small_calculator_arbiter.sv
// Self-checking bench for small_calculator_arbiter with a nominal 4-cycle calculator model.
module tb_small_calculator_arbiter;

  localparam int W = 4;
`ifdef SCA_TIMEOUT_EN
  localparam int TMO = 6;
`else
  localparam int TMO = 15;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic [3:0]     req;
  logic [7:0]     req_op;
  logic [4*W-1:0] req_in1;
  logic [4*W-1:0] req_in2;
  logic [3:0]     ack;
  logic [W-1:0]   result;
  logic           err;
  logic           busy;
  logic           calc_go;
  logic [1:0]     calc_op;
  logic [W-1:0]   calc_in1;
  logic [W-1:0]   calc_in2;
  logic           calc_done = 1'b0;
  logic [W-1:0]   calc_out;

  int passCount = 0;
  int totalCount = 0;
  logic modelEn = 1'b1;
  int modelCnt = 0;

  small_calculator_arbiter #(.W(W), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_op(req_op),
    .req_in1(req_in1), .req_in2(req_in2), .ack(ack), .result(result),
    .err(err), .busy(busy), .calc_go(calc_go), .calc_op(calc_op),
    .calc_in1(calc_in1), .calc_in2(calc_in2), .calc_done(calc_done),
    .calc_out(calc_out)
  );

  always #5 clk = ~clk;

  // Calculator model: done one cycle, four cycles after the go cycle.
  always @(posedge clk) begin
    calc_done <= 1'b0;
    if (calc_go) modelCnt <= 3;
    else if (modelCnt == 1) begin
      modelCnt  <= 0;
      calc_done <= modelEn;
    end else if (modelCnt != 0) modelCnt <= modelCnt - 1;
  end

  always_comb begin
    case (calc_op)
      2'b00:   calc_out = calc_in1 + calc_in2;
      2'b01:   calc_out = calc_in1 - calc_in2;
      2'b10:   calc_out = calc_in1 & calc_in2;
      default: calc_out = calc_in1 ^ calc_in2;
    endcase
  end

  typedef struct {
    string       name;
    logic [3:0]  req;
    logic [7:0]  op;
    logic [15:0] in1;
    logic [15:0] in2;
    logic [3:0]  expAck;
    logic [3:0]  expRes;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [7:0] op,
                               input logic [15:0] a, input logic [15:0] b);
    req     = r;
    req_op  = op;
    req_in1 = a;
    req_in2 = b;
  endtask

  // Waits (bounded) for the next ack and checks it, its data and its latency in negedges.
  task automatic checkOutput(input string name, input logic [3:0] expAck, input logic [3:0] expRes,
                             input logic expErr, input int expLat);
    int lat = 0;
    int goCnt = 0;
    bit seen = 0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (calc_go) goCnt++;
      if (ack != 4'b0000) seen = 1;
    end
    if (!seen) begin
      totalCount++;
      $display("[TB] FAIL %s_timeout: got no ack within %0d cycles expected ack %0h", name, lat, expAck);
    end else begin
      check({name, "_ack"}, 32'(ack), 32'(expAck));
      check({name, "_result"}, 32'(result), 32'(expRes));
      check({name, "_err"}, 32'(err), 32'(expErr));
      check({name, "_latency"}, 32'(lat), 32'(expLat));
      check({name, "_go_count"}, 32'(goCnt), 32'd1);
    end
  endtask

  logic [3:0] rrRes [5];

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{"sub_r1",    4'b0010, 8'h04, 16'h0020, 16'h0050, 4'b0010, 4'hD};
    vecs[1] = '{"and_r2",    4'b0100, 8'h20, 16'h0C00, 16'h0A00, 4'b0100, 4'h8};
    vecs[2] = '{"xor_r3",    4'b1000, 8'hC0, 16'hF000, 16'h5000, 4'b1000, 4'hA};
    vecs[3] = '{"add_wrap",  4'b0001, 8'h00, 16'h000F, 16'h0001, 4'b0001, 4'h0};
    vecs[4] = '{"ptr1_0101", 4'b0101, 8'h03, 16'h0704, 16'h0201, 4'b0100, 4'h9};
    vecs[5] = '{"ptr3_wrap", 4'b0011, 8'h01, 16'h0065, 16'h0061, 4'b0001, 4'h4};
    vecs[6] = '{"ptr1_0011", 4'b0011, 8'h01, 16'h0065, 16'h0061, 4'b0010, 4'hC};
    vecs[7] = '{"ptr2_0011", 4'b0011, 8'h01, 16'h0065, 16'h0061, 4'b0001, 4'h4};
    vecs[8] = '{"to_ptr0",   4'b1000, 8'hC0, 16'h3000, 16'h3000, 4'b1000, 4'h0};
    rrRes = '{4'h0, 4'h4, 4'h2, 4'hC, 4'h0};

    rst_n = 1'b0;
    applyStimulus(4'b0001, 8'h00, 16'h0003, 16'h0005);
    repeat (2) @(negedge clk);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_go", 32'(calc_go), 32'd0);
    check("rst_op", 32'(calc_op), 32'd0);
    check("rst_in1", 32'(calc_in1), 32'd0);
    check("rst_in2", 32'(calc_in2), 32'd0);

    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain_busy%0d", i), 32'(busy), 32'd1);
      check($sformatf("drain_go%0d", i), 32'(calc_go), 32'd0);
      @(negedge clk);
    end
    check("idle_busy", 32'(busy), 32'd0);
    checkOutput("first_add", 4'b0001, 4'h8, 1'b0, 6);

    for (int v = 0; v < 9; v++) begin
      applyStimulus(vecs[v].req, vecs[v].op, vecs[v].in1, vecs[v].in2);
      checkOutput(vecs[v].name, vecs[v].expAck, vecs[v].expRes, 1'b0, 7);
    end

    applyStimulus(4'b1111, 8'hE4, 16'hAAAA, 16'h6666);
    for (int k = 0; k < 5; k++)
      checkOutput($sformatf("rr%0d", k), 4'b0001 << (k % 4), rrRes[k], 1'b0, 7);

    applyStimulus(4'b0100, 8'h00, 16'h0100, 16'h0200);
    repeat (3) @(negedge clk);
    check("wait_busy", 32'(busy), 32'd1);
    check("wait_go", 32'(calc_go), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_ack", 32'(ack), 32'd0);
    check("midrst_go", 32'(calc_go), 32'd0);
    check("midrst_busy", 32'(busy), 32'd1);
    rst_n = 1'b1;
    checkOutput("after_reset", 4'b0100, 4'h3, 1'b0, 10);

`ifdef SCA_TIMEOUT_EN
    modelEn = 1'b0;
    applyStimulus(4'b0001, 8'h00, 16'h0003, 16'h0004);
    checkOutput("timeout", 4'b0001, 4'h0, 1'b1, 9);
    modelEn = 1'b1;
    applyStimulus(4'b0010, 8'h00, 16'h0020, 16'h0030);
    checkOutput("post_timeout", 4'b0010, 4'h5, 1'b0, 11);
`endif

    applyStimulus(4'b0000, 8'h00, 16'h0000, 16'h0000);
    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
